img_buf_arbiter: RTL and testbench

Arbitrates one single-port image buffer (SRAM, 1-cycle read latency) among three requesters: the CPU's memory-mapped bus (addr/re/we/wdata) and two streaming masters, M0 (camera/pixel writer) and M1 (VGA/feature reader). The CPU cannot stall, so it always has absolute priority. M0 and M1 share the remaining cycles round-robin through a req/gnt handshake. The block sits at top level between the cpu block, the buffer macro and the streaming engines.

---
 rtl/img_buf_arbiter.sv | 124 ++++++++++++
 tb/tb_img_buf_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/img_buf_arbiter.sv
// Single-port image buffer arbiter: the CPU wins combinationally, M0/M1 share idle cycles round-robin.
// Define ARB_STATS_EN to add the m0_wait_cnt/m1_wait_cnt saturating wait counters.
module img_buf_arbiter #(
  parameter int          AW        = 12,
  parameter logic [31:0] BASE_ADDR = 32'h0000_4000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [31:0]   cpu_addr,
  input  logic          cpu_re,
  input  logic          cpu_we,
  input  logic [31:0]   cpu_wdata,
  output logic [31:0]   cpu_rdata,
  output logic          cpu_rvalid,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [31:0]   m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [31:0]   m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [31:0]   m_rdata,
  output logic [AW-1:0] buf_addr,
  output logic          buf_re,
  output logic          buf_we,
  output logic [31:0]   buf_wdata,
  input  logic [31:0]   buf_rdata
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]   m0_wait_cnt,
  output logic [15:0]   m1_wait_cnt
`endif
);

  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_M0, OWN_M1} owner_t;

  localparam logic [31:0] NO_DATA = 32'h0000_DEAD;

  owner_t rd_owner;
  logic   rr_ptr;
  logic   cpu_hit;
  logic   gnt0;
  logic   gnt1;

  // Qualifying with rst_n keeps every enable and grant low while reset is held.
  assign cpu_hit = rst_n && (cpu_re || cpu_we) && (cpu_addr[31:AW] == BASE_ADDR[31:AW]);
  assign gnt0    = rst_n && !cpu_hit && m0_req && (!m1_req || (rr_ptr == 1'b0));
  assign gnt1    = rst_n && !cpu_hit && m1_req && (!m0_req || (rr_ptr == 1'b1));
  assign m0_gnt  = gnt0;
  assign m1_gnt  = gnt1;

  always_comb begin
    buf_addr  = '0;
    buf_re    = 1'b0;
    buf_we    = 1'b0;
    buf_wdata = '0;
    if (cpu_hit) begin
      buf_addr  = cpu_addr[AW-1:0];
      buf_we    = cpu_we;
      buf_re    = cpu_re && !cpu_we;
      buf_wdata = cpu_wdata;
    end else if (gnt0) begin
      buf_addr  = m0_addr;
      buf_we    = m0_we;
      buf_re    = !m0_we;
      buf_wdata = m0_wdata;
    end else if (gnt1) begin
      buf_addr  = m1_addr;
      buf_we    = m1_we;
      buf_re    = !m1_we;
      buf_wdata = m1_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= 1'b0;
      rd_owner <= OWN_NONE;
    end else begin
      if (gnt0) begin
        rr_ptr <= 1'b1;
      end else if (gnt1) begin
        rr_ptr <= 1'b0;
      end
      if (cpu_hit) begin
        rd_owner <= (cpu_re && !cpu_we) ? OWN_CPU : OWN_NONE;
      end else if (gnt0 && !m0_we) begin
        rd_owner <= OWN_M0;
      end else if (gnt1 && !m1_we) begin
        rd_owner <= OWN_M1;
      end else begin
        rd_owner <= OWN_NONE;
      end
    end
  end

  assign cpu_rvalid = (rd_owner == OWN_CPU);
  assign m0_rvalid  = (rd_owner == OWN_M0);
  assign m1_rvalid  = (rd_owner == OWN_M1);
  assign cpu_rdata  = cpu_rvalid ? buf_rdata : NO_DATA;
  assign m_rdata    = (m0_rvalid || m1_rvalid) ? buf_rdata : 32'h0;

`ifdef ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_wait_cnt <= 16'h0;
      m1_wait_cnt <= 16'h0;
    end else begin
      if (m0_req && !gnt0 && (m0_wait_cnt != 16'hFFFF)) begin
        m0_wait_cnt <= m0_wait_cnt + 16'd1;
      end
      if (m1_req && !gnt1 && (m1_wait_cnt != 16'hFFFF)) begin
        m1_wait_cnt <= m1_wait_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_img_buf_arbiter.sv
// Bench for img_buf_arbiter: behavioural 1-cycle SRAM, shadow memory and read-return scoreboards.
module tb_img_buf_arbiter;
  localparam int AW = 12;

  logic          clk;
  logic          rst_n;
  logic [31:0]   cpu_addr;
  logic          cpu_re;
  logic          cpu_we;
  logic [31:0]   cpu_wdata;
  logic [31:0]   cpu_rdata;
  logic          cpu_rvalid;
  logic          m0_req, m0_we, m0_gnt, m0_rvalid;
  logic [AW-1:0] m0_addr;
  logic [31:0]   m0_wdata;
  logic          m1_req, m1_we, m1_gnt, m1_rvalid;
  logic [AW-1:0] m1_addr;
  logic [31:0]   m1_wdata;
  logic [31:0]   m_rdata;
  logic [AW-1:0] buf_addr;
  logic          buf_re, buf_we;
  logic [31:0]   buf_wdata;
  logic [31:0]   buf_rdata;
`ifdef ARB_STATS_EN
  logic [15:0]   m0_wait_cnt, m1_wait_cnt;
`endif

  logic [31:0] sram    [0:4095];
  logic [31:0] ref_mem [0:4095];
  logic [31:0] cpu_q[$];
  logic [31:0] m0_q[$];
  logic [31:0] m1_q[$];
  int n_cmp;
  int n_mis;
  logic [31:0] exp_d;

  img_buf_arbiter #(.AW(AW), .BASE_ADDR(32'h0000_4000)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_addr(cpu_addr), .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .m_rdata(m_rdata), .buf_addr(buf_addr), .buf_re(buf_re), .buf_we(buf_we),
    .buf_wdata(buf_wdata), .buf_rdata(buf_rdata)
`ifdef ARB_STATS_EN
    , .m0_wait_cnt(m0_wait_cnt), .m1_wait_cnt(m1_wait_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (buf_we) sram[buf_addr] <= buf_wdata;
    if (buf_re) buf_rdata <= sram[buf_addr];
  end

  task automatic idle();
    cpu_addr = 32'h0; cpu_re = 1'b0; cpu_we = 1'b0; cpu_wdata = 32'h0;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = 32'h0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = 32'h0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cpu_q.delete(); m0_q.delete(); m1_q.delete();
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    cpu_addr = 32'h0000_4000; cpu_we = 1'b1; cpu_wdata = 32'h1111_1111;
    m0_req = 1'b1; m1_req = 1'b1;
    @(negedge clk); #1;
    n_cmp++; if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin n_mis++; $display("FAIL rst_gnt: got %b%b want 00", m0_gnt, m1_gnt); end
    n_cmp++; if (buf_we !== 1'b0 || buf_re !== 1'b0) begin n_mis++; $display("FAIL rst_buf_en: got we=%b re=%b want 0/0", buf_we, buf_re); end
    n_cmp++; if ({cpu_rvalid, m0_rvalid, m1_rvalid} !== 3'b000) begin n_mis++; $display("FAIL rst_rvalid: got %b want 000", {cpu_rvalid, m0_rvalid, m1_rvalid}); end
    n_cmp++; if (cpu_rdata !== 32'h0000_DEAD) begin n_mis++; $display("FAIL rst_cpu_rdata: got %h want 0000dead", cpu_rdata); end
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_cpu_access();
    cpu_addr = 32'h0000_4010; cpu_we = 1'b1; cpu_wdata = 32'h1234_5678; #1;
    n_cmp++; if (buf_we !== 1'b1 || buf_addr !== 12'h010 || buf_wdata !== 32'h1234_5678) begin n_mis++; $display("FAIL cpu_wr: got we=%b addr=%h d=%h want 1/010/12345678", buf_we, buf_addr, buf_wdata); end
    ref_mem[12'h010] = 32'h1234_5678;
    @(negedge clk);
    cpu_we = 1'b0; cpu_re = 1'b1; #1;
    n_cmp++; if (buf_re !== 1'b1 || buf_we !== 1'b0) begin n_mis++; $display("FAIL cpu_rd_issue: got re=%b we=%b want 1/0", buf_re, buf_we); end
    cpu_q.push_back(ref_mem[12'h010]);
    @(negedge clk);
    idle(); #1;
    n_cmp++;
    if (cpu_rvalid !== 1'b1 || cpu_q.size() == 0) begin n_mis++; $display("FAIL cpu_rd_ret: rvalid=%b want 1", cpu_rvalid); end
    else begin exp_d = cpu_q.pop_front(); if (cpu_rdata !== exp_d) begin n_mis++; $display("FAIL cpu_rd_data: got %h want %h", cpu_rdata, exp_d); end end
    @(negedge clk);
    // Out-of-window CPU read leaves the cycle to M1.
    cpu_addr = 32'h0000_C001; cpu_re = 1'b1;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 12'h055; m1_wdata = 32'hCAFE_0001; #1;
    n_cmp++; if (m1_gnt !== 1'b1 || buf_re !== 1'b0 || buf_addr !== 12'h055) begin n_mis++; $display("FAIL cpu_miss: got gnt=%b re=%b addr=%h want 1/0/055", m1_gnt, buf_re, buf_addr); end
    ref_mem[12'h055] = 32'hCAFE_0001;
    @(negedge clk);
    idle(); #1;
    n_cmp++; if (cpu_rvalid !== 1'b0 || cpu_rdata !== 32'h0000_DEAD) begin n_mis++; $display("FAIL cpu_miss_ret: got v=%b d=%h want 0/0000dead", cpu_rvalid, cpu_rdata); end
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    logic exp0;
    do_reset();
    m0_req = 1'b1; m0_we = 1'b1; m1_req = 1'b1; m1_we = 1'b1;
    for (int i = 0; i < 4; i++) begin
      m0_addr = 12'h100 + 12'(i); m0_wdata = 32'hA000_0000 + 32'(i);
      m1_addr = 12'h200 + 12'(i); m1_wdata = 32'hB000_0000 + 32'(i);
      #1;
      exp0 = (i % 2 == 0);
      n_cmp++; if (m0_gnt !== exp0 || m1_gnt !== !exp0) begin n_mis++; $display("FAIL rr_%0d: got m0=%b m1=%b want m0=%b m1=%b", i, m0_gnt, m1_gnt, exp0, !exp0); end
      if (exp0) ref_mem[m0_addr] = m0_wdata; else ref_mem[m1_addr] = m1_wdata;
      @(negedge clk);
    end
    m1_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m0_addr = 12'h300 + 12'(i); m0_wdata = 32'hC000_0000 + 32'(i); #1;
      n_cmp++; if (m0_gnt !== 1'b1 || buf_addr !== m0_addr) begin n_mis++; $display("FAIL b2b_%0d: got gnt=%b addr=%h want 1/%h", i, m0_gnt, buf_addr, m0_addr); end
      ref_mem[m0_addr] = m0_wdata;
      @(negedge clk);
    end
    idle();
    @(negedge clk);
  endtask

  task automatic test_cpu_priority();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 12'h010;
    cpu_addr = 32'h0000_4201; cpu_re = 1'b1; #1;
    n_cmp++; if (m0_gnt !== 1'b0 || buf_addr !== 12'h201 || buf_re !== 1'b1) begin n_mis++; $display("FAIL prio_block: got gnt=%b addr=%h re=%b want 0/201/1", m0_gnt, buf_addr, buf_re); end
    cpu_q.push_back(ref_mem[12'h201]);
    @(negedge clk);
    cpu_re = 1'b0; #1;
    n_cmp++; if (m0_gnt !== 1'b1 || buf_addr !== 12'h010 || buf_re !== 1'b1) begin n_mis++; $display("FAIL prio_gnt: got gnt=%b addr=%h re=%b want 1/010/1", m0_gnt, buf_addr, buf_re); end
    m0_q.push_back(ref_mem[12'h010]);
    n_cmp++;
    if (cpu_rvalid !== 1'b1 || cpu_q.size() == 0) begin n_mis++; $display("FAIL prio_cpu_ret: rvalid=%b want 1", cpu_rvalid); end
    else begin exp_d = cpu_q.pop_front(); if (cpu_rdata !== exp_d) begin n_mis++; $display("FAIL prio_cpu_data: got %h want %h", cpu_rdata, exp_d); end end
    @(negedge clk);
    m0_req = 1'b0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 12'h203; #1;
    n_cmp++; if (m1_gnt !== 1'b1) begin n_mis++; $display("FAIL m1_rd_gnt: got %b want 1", m1_gnt); end
    m1_q.push_back(ref_mem[12'h203]);
    n_cmp++;
    if (m0_rvalid !== 1'b1 || m1_rvalid !== 1'b0 || m0_q.size() == 0) begin n_mis++; $display("FAIL m0_ret: got m0v=%b m1v=%b want 1/0", m0_rvalid, m1_rvalid); end
    else begin exp_d = m0_q.pop_front(); if (m_rdata !== exp_d) begin n_mis++; $display("FAIL m0_data: got %h want %h", m_rdata, exp_d); end end
    @(negedge clk);
    idle(); #1;
    n_cmp++;
    if (m1_rvalid !== 1'b1 || m0_rvalid !== 1'b0 || m1_q.size() == 0) begin n_mis++; $display("FAIL m1_ret: got m1v=%b m0v=%b want 1/0", m1_rvalid, m0_rvalid); end
    else begin exp_d = m1_q.pop_front(); if (m_rdata !== exp_d) begin n_mis++; $display("FAIL m1_data: got %h want %h", m_rdata, exp_d); end end
    @(negedge clk);
  endtask

  task automatic test_rw_both();
    cpu_addr = 32'h0000_4030; cpu_re = 1'b1; cpu_we = 1'b1; cpu_wdata = 32'h5A5A_A5A5; #1;
    n_cmp++; if (buf_we !== 1'b1 || buf_re !== 1'b0 || buf_addr !== 12'h030) begin n_mis++; $display("FAIL rw_issue: got we=%b re=%b addr=%h want 1/0/030", buf_we, buf_re, buf_addr); end
    ref_mem[12'h030] = 32'h5A5A_A5A5;
    @(negedge clk);
    cpu_we = 1'b0; #1;
    n_cmp++; if (cpu_rvalid !== 1'b0 || cpu_rdata !== 32'h0000_DEAD) begin n_mis++; $display("FAIL rw_no_ret: got v=%b d=%h want 0/0000dead", cpu_rvalid, cpu_rdata); end
    cpu_q.push_back(ref_mem[12'h030]);
    @(negedge clk);
    idle(); #1;
    n_cmp++;
    if (cpu_rvalid !== 1'b1 || cpu_q.size() == 0) begin n_mis++; $display("FAIL rw_readback: rvalid=%b want 1", cpu_rvalid); end
    else begin exp_d = cpu_q.pop_front(); if (cpu_rdata !== exp_d) begin n_mis++; $display("FAIL rw_data: got %h want %h", cpu_rdata, exp_d); end end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 12'h030; #1;
    n_cmp++; if (m1_gnt !== 1'b1) begin n_mis++; $display("FAIL midrst_gnt: got %b want 1", m1_gnt); end
    @(posedge clk); #1;
    rst_n = 1'b0;
    cpu_addr = 32'h0000_4040; cpu_we = 1'b1; cpu_wdata = 32'hDEAD_BEEF; m0_req = 1'b1; m0_we = 1'b1;
    @(negedge clk); #1;
    n_cmp++; if (m1_rvalid !== 1'b0 || m0_rvalid !== 1'b0 || cpu_rvalid !== 1'b0) begin n_mis++; $display("FAIL midrst_rvalid: got m1v=%b want 0", m1_rvalid); end
    n_cmp++; if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0 || buf_we !== 1'b0 || buf_re !== 1'b0) begin n_mis++; $display("FAIL midrst_outs: gnt=%b%b we=%b re=%b want 0", m0_gnt, m1_gnt, buf_we, buf_re); end
    n_cmp++; if (cpu_rdata !== 32'h0000_DEAD) begin n_mis++; $display("FAIL midrst_rdata: got %h want 0000dead", cpu_rdata); end
    m1_q.delete();
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cpu_addr = 32'h0000_4030; cpu_re = 1'b1; #1;
    cpu_q.push_back(ref_mem[12'h030]);
    @(negedge clk);
    cpu_addr = 32'h0000_4040; #1;
    n_cmp++;
    if (cpu_rvalid !== 1'b1 || cpu_q.size() == 0) begin n_mis++; $display("FAIL postrst_rd0: rvalid=%b want 1", cpu_rvalid); end
    else begin exp_d = cpu_q.pop_front(); if (cpu_rdata !== exp_d) begin n_mis++; $display("FAIL postrst_d0: got %h want %h", cpu_rdata, exp_d); end end
    cpu_q.push_back(ref_mem[12'h040]);
    @(negedge clk);
    idle(); #1;
    n_cmp++;
    if (cpu_rvalid !== 1'b1 || cpu_q.size() == 0) begin n_mis++; $display("FAIL postrst_rd1: rvalid=%b want 1", cpu_rvalid); end
    else begin exp_d = cpu_q.pop_front(); if (cpu_rdata !== exp_d) begin n_mis++; $display("FAIL postrst_d1: got %h want %h", cpu_rdata, exp_d); end end
    @(negedge clk);
  endtask

  task automatic test_starve_stats();
    do_reset();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 12'h060; m0_wdata = 32'h0606_0606;
    for (int i = 0; i < 5; i++) begin
      cpu_addr = 32'h0000_4050 + 32'(i); cpu_we = 1'b1; cpu_wdata = 32'hE000_0000 + 32'(i); #1;
      n_cmp++; if (m0_gnt !== 1'b0) begin n_mis++; $display("FAIL starve_%0d: got gnt=%b want 0", i, m0_gnt); end
      ref_mem[12'h050 + 12'(i)] = cpu_wdata;
      @(negedge clk);
    end
    cpu_we = 1'b0; #1;
    n_cmp++; if (m0_gnt !== 1'b1 || buf_addr !== 12'h060) begin n_mis++; $display("FAIL starve_release: got gnt=%b addr=%h want 1/060", m0_gnt, buf_addr); end
    ref_mem[12'h060] = 32'h0606_0606;
    @(negedge clk);
    idle(); #1;
`ifdef ARB_STATS_EN
    n_cmp++; if (m0_wait_cnt !== 16'd5 || m1_wait_cnt !== 16'd0) begin n_mis++; $display("FAIL wait_cnt: got m0=%0d m1=%0d want 5/0", m0_wait_cnt, m1_wait_cnt); end
`endif
    cpu_addr = 32'h0000_4054; cpu_re = 1'b1; #1;
    cpu_q.push_back(ref_mem[12'h054]);
    @(negedge clk);
    idle(); #1;
    n_cmp++;
    if (cpu_rvalid !== 1'b1 || cpu_q.size() == 0) begin n_mis++; $display("FAIL starve_rd: rvalid=%b want 1", cpu_rvalid); end
    else begin exp_d = cpu_q.pop_front(); if (cpu_rdata !== exp_d) begin n_mis++; $display("FAIL starve_data: got %h want %h", cpu_rdata, exp_d); end end
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    for (int i = 0; i < 4096; i++) begin
      sram[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end
    idle();
    rst_n = 1'b0;
    test_reset();
    test_cpu_access();
    test_round_robin();
    test_cpu_priority();
    test_rw_both();
    test_reset_mid();
    test_starve_stats();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
